// File: rtl/key_input_port_if.sv
// CPU read bus of the key input port.
// The master issues one-cycle read strobes; the slave returns registered read data.
interface key_input_port_if;
  logic        rd_en;
  logic        rd_addr;
  logic [31:0] rd_data;

  modport master (output rd_en, output rd_addr, input  rd_data);
  modport slave  (input  rd_en, input  rd_addr, output rd_data);
endinterface

// File: rtl/key_input_port.sv
// Debounced push-button / slide-switch input port with a two-register CPU read interface.
// Optional build macro KEY_INPUT_PORT_SW_DEBOUNCE_EN adds per-bit debouncing of the switches.
module key_input_port #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      key_n,
  input  logic [9:0]      sw,
  key_input_port_if.slave bus,
  output logic            step_pulse,
  output logic            evt_pending
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  logic [1:0]  key_sync_p0;
  logic [1:0]  key_sync_p1;
  logic [9:0]  sw_sync_p0;
  logic [9:0]  sw_sync_p1;
  logic [1:0]  key_pressed;
  logic [1:0]  key_lvl;
  logic [1:0]  accept;
  logic [1:0]  evt;
  logic [7:0]  press_cnt;
  logic [9:0]  sw_filtered;
  logic        evt_clr;
  logic [31:0] rd_mux;

  // Stage p0/p1: two-flop synchronizers; keys idle released (high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sync_p0 <= 2'b11;
      key_sync_p1 <= 2'b11;
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      key_sync_p0 <= key_n;
      key_sync_p1 <= key_sync_p0;
      sw_sync_p0  <= sw;
      sw_sync_p1  <= sw_sync_p0;
    end
  end

  assign key_pressed = ~key_sync_p1;

  for (genvar g = 0; g < 2; g++) begin : g_key
    key_state_t    state_q;
    key_state_t    state_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          lvl;
    logic          acc;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
      end else begin
        state_q <= state_nxt;
        cnt_q   <= cnt_nxt;
      end
    end

    always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      case (state_q)
        RELEASED: begin
          if (key_pressed[g]) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_pressed[g]) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_nxt = PRESSED;
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!key_pressed[g]) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_pressed[g]) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_nxt = RELEASED;
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end

    // A press is accepted on the very edge that leaves PRESS_WAIT for PRESSED.
    always_comb begin
      lvl = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
      acc = (state_q == PRESS_WAIT) && key_pressed[g] && (cnt_q == CNT_MAX);
    end

    assign key_lvl[g] = lvl;
    assign accept[g]  = acc;
  end

`ifdef KEY_INPUT_PORT_SW_DEBOUNCE_EN
  // Each switch bit flips only after DEBOUNCE_CYCLES consecutive differing samples.
  for (genvar b = 0; b < 10; b++) begin : g_sw
    logic [CW-1:0] sw_cnt;
    logic          sw_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sw_cnt <= '0;
        sw_q   <= 1'b0;
      end else if (sw_sync_p1[b] == sw_q) begin
        sw_cnt <= '0;
      end else if (sw_cnt == CNT_MAX) begin
        sw_q   <= sw_sync_p1[b];
        sw_cnt <= '0;
      end else begin
        sw_cnt <= sw_cnt + CW'(1);
      end
    end

    assign sw_filtered[b] = sw_q;
  end
`else
  assign sw_filtered = sw_sync_p1;
`endif

  assign evt_clr     = bus.rd_en & bus.rd_addr;
  assign evt_pending = evt[0] | evt[1];

  always_comb begin
    if (bus.rd_addr)
      rd_mux = {16'b0, press_cnt, 2'b0, key_lvl, 2'b0, evt};
    else
      rd_mux = {22'b0, sw_filtered};
  end

  // Stage p2: event flags, press counter, step pulse and read data.
  // A status read clears evt, but a press accepted on that same edge wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt         <= '0;
      press_cnt   <= '0;
      step_pulse  <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      evt        <= (evt & {2{~evt_clr}}) | accept;
      press_cnt  <= press_cnt + {7'b0, accept[0]};
      step_pulse <= accept[0];
      if (bus.rd_en)
        bus.rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_key_input_port.sv
// Directed bench for key_input_port with DEBOUNCE_CYCLES=4 and hand-computed expectations.
module tb_key_input_port;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_n = 2'b11;
  logic [9:0] sw = '0;
  logic       step_pulse;
  logic       evt_pending;

  int checks   = 0;
  int failures = 0;

  key_input_port_if bus ();

  key_input_port #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .sw          (sw),
    .bus         (bus),
    .step_pulse  (step_pulse),
    .evt_pending (evt_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs n edges, reporting the 1-based edge index of the first step pulse and the pulse count.
  task automatic scan(input int n, output int first, output int cnt);
    first = 0;
    cnt   = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (step_pulse === 1'b1) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
  endtask

  task automatic rd(input logic a);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_en   = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] k);
    rst   = 1'b1;
    key_n = k;
    tick(2);
    rst   = 1'b0;
  endtask

  initial begin
    int first;
    int cnt;
    int total;
    int lat;

    bus.rd_en   = 1'b0;
    bus.rd_addr = 1'b0;

    // Reset state, key 0 held low across reset release.
    do_reset(2'b10);
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_step", {31'b0, step_pulse}, 32'h0);
    check("rst_evt_pending", {31'b0, evt_pending}, 32'h0);
    scan(12, first, cnt);
    check("hold_pulse_edge", first, 7);
    check("hold_pulse_cnt", cnt, 1);
    check("hold_evt_pending", {31'b0, evt_pending}, 32'h1);
    rd(1'b1);
    check("hold_status", bus.rd_data, 32'h0000_0111);
    check("status_clr_pending", {31'b0, evt_pending}, 32'h0);
    rd(1'b1);
    check("status_after_clr", bus.rd_data, 32'h0000_0110);
    tick(3);
    check("rd_hold", bus.rd_data, 32'h0000_0110);

    // Bounce: low 3, high 1, then steady low.
    do_reset(2'b11);
    key_n = 2'b10;
    scan(3, first, cnt);
    total = cnt;
    key_n = 2'b11;
    scan(1, first, cnt);
    total += cnt;
    check("bounce_no_pulse", total, 0);
    key_n = 2'b10;
    scan(12, first, cnt);
    check("bounce_pulse_edge", first, 7);
    check("bounce_pulse_cnt", cnt, 1);
    rd(1'b1);
    check("bounce_press_cnt", {24'b0, bus.rd_data[15:8]}, 32'h1);

    // Reset while PRESS_WAIT counter is at 2; key stays held.
    do_reset(2'b11);
    key_n = 2'b10;
    scan(5, first, cnt);
    check("pw_no_pulse", cnt, 0);
    rst = 1'b1;
    #1;
    check("pw_rst_step", {31'b0, step_pulse}, 32'h0);
    tick(2);
    rst = 1'b0;
    scan(12, first, cnt);
    check("pw_rst_pulse_edge", first, 7);
    check("pw_rst_pulse_cnt", cnt, 1);

    // Status read on the edge that accepts key 1.
    rd(1'b1);
    check("pre_k1_status", bus.rd_data, 32'h0000_0111);
    key_n = 2'b00;
    scan(6, first, cnt);
    check("k1_wait_no_pulse", cnt, 0);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 1'b1;
    tick();
    bus.rd_en   = 1'b0;
    check("k1_accept_rd", bus.rd_data, 32'h0000_0110);
    check("k1_no_step", {31'b0, step_pulse}, 32'h0);
    check("k1_evt_pending", {31'b0, evt_pending}, 32'h1);
    rd(1'b1);
    check("k1_status", bus.rd_data, 32'h0000_0132);

    // Simultaneous presses on both keys.
    do_reset(2'b00);
    scan(12, first, cnt);
    check("dual_pulse_edge", first, 7);
    check("dual_evt_pending", {31'b0, evt_pending}, 32'h1);
    rd(1'b1);
    check("dual_status", bus.rd_data, 32'h0000_0133);
    rst = 1'b1;
    #1;
    check("async_rst_rd_data", bus.rd_data, 32'h0);
    check("async_rst_pending", {31'b0, evt_pending}, 32'h0);

    // 256 presses: press counter wraps.
    do_reset(2'b11);
    total = 0;
    for (int p = 1; p <= 256; p++) begin
      key_n = 2'b10;
      scan(8, first, cnt);
      total += cnt;
      key_n = 2'b11;
      scan(8, first, cnt);
      total += cnt;
      if (p == 255) begin
        rd(1'b1);
        check("press_255_status", bus.rd_data, 32'h0000_FF01);
      end
    end
    check("press_256_pulses", total, 256);
    check("wrap_evt_pending", {31'b0, evt_pending}, 32'h1);
    rd(1'b1);
    check("wrap_status", bus.rd_data, 32'h0000_0001);

    // Switch register read latency.
`ifdef KEY_INPUT_PORT_SW_DEBOUNCE_EN
    lat = 2 + D;
`else
    lat = 2;
`endif
    sw = 10'h2A5;
    tick(lat - 1);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 1'b0;
    tick();
    check("sw_early", bus.rd_data, 32'h0);
    tick();
    bus.rd_en = 1'b0;
    check("sw_value", bus.rd_data, 32'h0000_02A5);
    sw = 10'h15A;
    tick(8);
    check("sw_hold", bus.rd_data, 32'h0000_02A5);
    rd(1'b0);
    check("sw_value2", bus.rd_data, 32'h0000_015A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
